// File: rtl/cp0_unit_pkg.sv
// ============================================================================
//  Module : cp0_unit_pkg
//  Brief  : CP0 register numbers, SR/Cause field positions and ExcCode values.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cp0_unit_pkg;

  localparam logic [4:0] c_reg_count   = 5'd9;
  localparam logic [4:0] c_reg_compare = 5'd11;
  localparam logic [4:0] c_reg_sr      = 5'd12;
  localparam logic [4:0] c_reg_cause   = 5'd13;
  localparam logic [4:0] c_reg_epc     = 5'd14;
  localparam logic [4:0] c_reg_prid    = 5'd15;

  localparam int c_sr_ie      = 0;
  localparam int c_sr_exl     = 1;
  localparam int c_im_lo      = 10;
  localparam int c_im_hi      = 15;
  localparam int c_cause_bd   = 31;
  localparam int c_exccode_lo = 2;
  localparam int c_exccode_hi = 6;

  localparam logic [4:0] c_exc_int  = 5'd0;
  localparam logic [4:0] c_exc_adel = 5'd4;
  localparam logic [4:0] c_exc_ades = 5'd5;
  localparam logic [4:0] c_exc_ri   = 5'd10;
  localparam logic [4:0] c_exc_ov   = 5'd12;

endpackage

`default_nettype wire

// File: rtl/cp0_unit_timer.sv
// ============================================================================
//  Module : cp0_timer
//  Brief  : Free-running Count, Compare and sticky timer-pending flag.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count,
  input  logic        we_compare,
  input  logic [31:0] din,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_pend
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_compare <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_count <= we_count ? din : r_count + 32'd1;
      if (we_compare) begin
        r_compare <= din;
        r_pend    <= 1'b0;
      end else if ((r_count == r_compare) && (r_compare != 32'd0)) begin
        r_pend <= 1'b1;
      end
    end
  end

  assign count      = r_count;
  assign compare    = r_compare;
  assign timer_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
//  Module : cp0_unit
//  Brief  : CP0 exception/interrupt controller (SR/Cause/EPC/PRId) at M stage.
//           Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h0000_2020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC_M,
  input  logic [31:0] PC_E,
  input  logic        BD_M,
  input  logic [4:0]  ExcCodeM,
  input  logic        EXLClr,
  input  logic [5:0]  HWInt,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic [5:0]  w_hwint;
  logic        w_int_pend;
  logic        w_exc_pend;
  logic        w_mtc0;
  logic [31:0] w_epc_base;
  logic [31:0] w_epc_next;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

`ifdef CP0_TIMER_EN
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_timer_pend;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .we_count   (w_mtc0 && (A2 == c_reg_count)),
    .we_compare (w_mtc0 && (A2 == c_reg_compare)),
    .din        (DIn),
    .count      (w_count),
    .compare    (w_compare),
    .timer_pend (w_timer_pend)
  );

  assign w_hwint = {HWInt[5] | w_timer_pend, HWInt[4:0]};
`else
  assign w_hwint = HWInt;
`endif

  assign w_int_pend = (|(w_hwint & r_im)) & r_ie & ~r_exl;
  assign w_exc_pend = (ExcCodeM != 5'd0) & ~r_exl;
  assign IntReq     = w_int_pend | w_exc_pend;
  assign w_mtc0     = WE & ~IntReq;

  // A bubble in M has no PC of its own; resume at the instruction behind it.
  assign w_epc_base = (PC_M != 32'd0) ? PC_M : PC_E;
  assign w_epc_next = BD_M ? (w_epc_base - 32'd4) : w_epc_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= w_hwint;
      if (IntReq) begin
        r_exl     <= 1'b1;
        r_bd      <= BD_M;
        r_exccode <= w_int_pend ? c_exc_int : ExcCodeM;
        r_epc     <= w_epc_next & ~32'h3;
      end else begin
        if (w_mtc0 && (A2 == c_reg_sr)) begin
          r_im  <= DIn[c_im_hi:c_im_lo];
          r_ie  <= DIn[c_sr_ie];
          r_exl <= DIn[c_sr_exl] & ~EXLClr;
        end else if (EXLClr) begin
          r_exl <= 1'b0;
        end
        if (w_mtc0 && (A2 == c_reg_epc)) begin
          r_epc <= DIn & ~32'h3;
        end
      end
    end
  end

  always_comb begin
    w_sr                           = '0;
    w_sr[c_im_hi:c_im_lo]          = r_im;
    w_sr[c_sr_exl]                 = r_exl;
    w_sr[c_sr_ie]                  = r_ie;
    w_cause                        = '0;
    w_cause[c_cause_bd]            = r_bd;
    w_cause[c_im_hi:c_im_lo]       = r_ip;
    w_cause[c_exccode_hi:c_exccode_lo] = r_exccode;
  end

  always_comb begin
    DOut = '0;
    case (A1)
      c_reg_sr:      DOut = w_sr;
      c_reg_cause:   DOut = w_cause;
      c_reg_epc:     DOut = r_epc;
      c_reg_prid:    DOut = PRID_VAL;
`ifdef CP0_TIMER_EN
      c_reg_count:   DOut = w_count;
      c_reg_compare: DOut = w_compare;
`endif
      default:       DOut = '0;
    endcase
  end

  assign EPC = r_epc;

endmodule

`default_nettype wire

// File: tb/tb_cp0_unit.sv
// ============================================================================
//  Module : tb_cp0_unit
//  Brief  : Directed and random stimulus for cp0_unit against a word-level model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0000_2020;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, ExcCodeM;
  logic [31:0] DIn, PC_M, PC_E;
  logic        WE, BD_M, EXLClr;
  logic [5:0]  HWInt;
  logic        IntReq;
  logic [31:0] EPC, DOut;

  cp0_unit #(.PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
    .PC_M(PC_M), .PC_E(PC_E), .BD_M(BD_M), .ExcCodeM(ExcCodeM),
    .EXLClr(EXLClr), .HWInt(HWInt), .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Model state kept as whole architectural words.
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  logic        m_tpend = 1'b0;
  logic        m_valid = 1'b0;

  function automatic logic [5:0] m_hw();
    return HWInt | (m_tpend ? 6'b100000 : 6'b000000);
  endfunction

  function automatic logic m_int();
    return ((m_hw() & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int() || ((ExcCodeM != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
`ifdef CP0_TIMER_EN
      5'd9:    return m_count;
      5'd11:   return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_update();
    logic        req, intp, wr;
    logic [31:0] nsr, ncause, nepc, base;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_tpend = 0;
      m_valid = 1'b1;
      return;
    end
    req    = m_req();
    intp   = m_int();
    nsr    = m_sr;
    nepc   = m_epc;
    ncause = (m_cause & ~32'h0000_FC00) | ({26'd0, m_hw()} << 10);
    if (req) begin
      nsr       = nsr | 32'h2;
      ncause    = (ncause & ~32'h8000_007C) | ({31'd0, BD_M} << 31)
                  | ({27'd0, (intp ? 5'd0 : ExcCodeM)} << 2);
      base      = (PC_M != 0) ? PC_M : PC_E;
      nepc      = (base - (BD_M ? 32'd4 : 32'd0)) & ~32'h3;
    end else begin
      if (WE && A2 == 5'd12) nsr = DIn & 32'h0000_FC03;
      if (EXLClr) nsr = nsr & ~32'h2;
      if (WE && A2 == 5'd14) nepc = DIn & ~32'h3;
    end
    wr = WE && !req;
`ifdef CP0_TIMER_EN
    if (wr && A2 == 5'd11) m_tpend = 1'b0;
    else if (m_count == m_compare && m_compare != 0) m_tpend = 1'b1;
    m_count = (wr && A2 == 5'd9) ? DIn : m_count + 1;
    if (wr && A2 == 5'd11) m_compare = DIn;
`else
    if (wr) m_tpend = 1'b0;
`endif
    m_sr = nsr; m_cause = ncause; m_epc = nepc;
  endtask

  // Inputs are set at the falling edge; outputs are compared just after.
  task automatic cycle();
    #1;
    if (m_valid) begin
      chk("IntReq", {31'd0, IntReq}, {31'd0, m_req()});
      chk("EPC", EPC, m_epc);
      chk("DOut", DOut, m_read(A1));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic lit(input logic [4:0] a, input logic [31:0] exp, input string name);
    A1 = a;
    #1;
    chk(name, DOut, exp);
  endtask

  task automatic lit_req(input logic exp, input string name);
    #1;
    chk(name, {31'd0, IntReq}, {31'd0, exp});
  endtask

  task automatic idle();
    WE = 0; A2 = 0; DIn = 0; PC_M = 0; PC_E = 0; BD_M = 0;
    ExcCodeM = 0; EXLClr = 0; HWInt = 0;
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd12;
    idle();
    @(negedge clk);
    cycle(); cycle();
    reset = 1'b0;
    #1;
    chk("reset_intreq", {31'd0, IntReq}, 32'd0);
    chk("reset_epc", EPC, 32'd0);
    lit(5'd12, 32'd0, "reset_sr");
    lit(5'd13, 32'd0, "reset_cause");

    // Interrupt through IM[12]
    WE = 1; A2 = 5'd12; DIn = 32'h0000_FC01; cycle(); idle();
    HWInt = 6'b000100; PC_M = 32'h0000_3000;
    lit_req(1'b1, "int_req");
    cycle(); idle();
    lit(5'd12, 32'h0000_FC03, "int_sr_exl");
    lit(5'd13, 32'h0000_1000, "int_cause");
    lit(5'd14, 32'h0000_3000, "int_epc");

    // Overflow in a delay slot
    EXLClr = 1; cycle(); idle();
    ExcCodeM = 5'd12; BD_M = 1; PC_M = 32'h0000_3010;
    lit_req(1'b1, "ov_req");
    cycle(); idle();
    lit(5'd14, 32'h0000_300C, "ov_epc");
    lit(5'd13, 32'h8000_0030, "ov_cause");

    // Nested events blocked while EXL=1, taken after eret
    ExcCodeM = 5'd4; HWInt = 6'b000100;
    lit_req(1'b0, "nested_blocked");
    cycle();
    ExcCodeM = 0; EXLClr = 1;
    lit_req(1'b0, "eret_cycle");
    cycle();
    EXLClr = 0; PC_M = 32'h0000_3040;
    lit_req(1'b1, "after_eret");
    cycle(); idle();
    lit(5'd14, 32'h0000_3040, "after_eret_epc");

    // mtc0 EPC dropped under IntReq, then bubble EPC
    EXLClr = 1; cycle(); idle();
    ExcCodeM = 5'd5; PC_M = 32'h0000_3050; WE = 1; A2 = 5'd14; DIn = 32'h0000_3008;
    cycle(); idle();
    lit(5'd14, 32'h0000_3050, "we_dropped");
    EXLClr = 1; cycle(); idle();
    ExcCodeM = 5'd10; PC_M = 0; PC_E = 32'h0000_3020;
    cycle(); idle();
    lit(5'd14, 32'h0000_3020, "bubble_epc");

    // mfc0 reads (EXL still 1)
    lit(5'd15, PRID, "prid");
    lit(5'd7, 32'd0, "reg7");
    HWInt = 6'b101010; cycle(); HWInt = 0;
    lit(5'd13, 32'h0000_A828, "cause_ip");
    WE = 1; A2 = 5'd14; DIn = 32'h0000_1234;
    lit(5'd14, 32'h0000_3020, "no_bypass");
    cycle(); idle();
    lit(5'd14, 32'h0000_1234, "epc_written");
    WE = 1; A2 = 5'd13; DIn = 32'hFFFF_FFFF; cycle(); idle();
    lit(5'd13, 32'h0000_0028, "cause_ro");

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] sel;
      reset    = ($urandom_range(0, 299) == 0);
      HWInt    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      sel      = 3'($urandom_range(0, 7));
      ExcCodeM = (sel == 0) ? 5'd4 : (sel == 1) ? 5'd12 : (sel == 2) ? 5'd10 : 5'd0;
      WE       = ($urandom_range(0, 3) == 0);
      sel      = 3'($urandom_range(0, 7));
      A2       = (sel < 3) ? 5'd12 : (sel == 3) ? 5'd13 : (sel == 4) ? 5'd14 :
                 (sel == 5) ? 5'd9 : (sel == 6) ? 5'd11 : 5'($urandom);
      DIn      = $urandom;
      if (A2 == 5'd11 && $urandom_range(0, 1) == 0) DIn = 32'($urandom_range(1, 40));
      EXLClr   = ($urandom_range(0, 2) == 0);
      PC_M     = ($urandom_range(0, 3) == 0) ? 32'd0 : ({$urandom} & ~32'h3);
      PC_E     = $urandom & ~32'h3;
      BD_M     = 1'($urandom);
      sel      = 3'($urandom_range(0, 7));
      A1       = (sel == 0) ? 5'd12 : (sel == 1) ? 5'd13 : (sel == 2) ? 5'd14 :
                 (sel == 3) ? 5'd15 : (sel == 4) ? 5'd9 : (sel == 5) ? 5'd11 : 5'($urandom);
      cycle();
    end
    reset = 0;
    idle();
    cycle();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
